// File: rtl/mips_pkg.sv
// Shared definitions for the preload/execute controller.
//   HALT_INSTR   : default encoding of the halt instruction
//   exec_state_e : controller state codes (LOAD=0, RUN=1, STEP=2, DONE=3)
package mips_pkg;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StLoad = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2,
    StDone = 2'd3
  } exec_state_e;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for an already-synchronous level signal.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (clears the history bit)
//   i_sig  : level input
//   o_rise : high in the cycle where i_sig is 1 and was 0 on the previous cycle
module edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise
);

  logic sig_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= i_sig;
    end
  end

  assign o_rise = i_sig & ~sig_q;

endmodule

// File: rtl/preload_exec_ctrl.sv
// Program preload and execution controller for a small pipelined CPU.
// Loads program words into program memory, then releases the pipeline either
// free-running or one cycle per step request, and stops a fixed number of enabled
// cycles after the halt instruction reaches IF/ID.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_word_valid/i_word     : program word source; o_word_ready accepts (LOAD only)
//   i_step_mode_flag        : 1 = step mode after load, 0 = continuous
//   i_step                  : step request level
//   i_ifid_instr            : instruction currently in the IF/ID latch
//   o_preload_*             : program memory write strobe / address / data
//   o_cpu_rst, o_cpu_en     : pipeline reset and advance enable
//   o_cycle_count           : enabled execution cycles (saturating)
//   o_halted, o_load_full   : DONE indicator, load ended on a full memory
//   o_state                 : current state code
module preload_exec_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned    LEN               = 32,
  parameter int unsigned    RAM_DEPTH_PROGRAM = 32,
  parameter logic [LEN-1:0] HALT_WORD         = LEN'(HALT_INSTR),
  parameter int unsigned    DRAIN_CYCLES      = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_word_valid,
  input  logic [LEN-1:0] i_word,
  output logic           o_word_ready,
  input  logic           i_step_mode_flag,
  input  logic           i_step,
  input  logic [LEN-1:0] i_ifid_instr,
  output logic           o_preload_flag,
  output logic [LEN-1:0] o_preload_address,
  output logic [LEN-1:0] o_preload_instruction,
  output logic           o_cpu_rst,
  output logic           o_cpu_en,
  output logic [31:0]    o_cycle_count,
  output logic           o_halted,
  output logic           o_load_full,
  output logic [1:0]     o_state
);

  localparam int unsigned    HcW      = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [HcW-1:0] DrainCnt = HcW'(DRAIN_CYCLES);
  localparam logic [LEN-1:0] LastAddr = LEN'(RAM_DEPTH_PROGRAM - 1);

  exec_state_e    state_q, state_d;
  logic [LEN-1:0] ptr_q, ptr_d;
  logic [HcW-1:0] halt_cnt_q, halt_cnt_d;
  logic [31:0]    cycle_q, cycle_d;
  logic           flag_q, flag_d;
  logic [LEN-1:0] addr_q, addr_d;
  logic [LEN-1:0] instr_q, instr_d;
  logic           cpu_rst_q, cpu_rst_d;
  logic           cpu_en_q, cpu_en_d;
  logic           halted_q, halted_d;
  logic           load_full_q, load_full_d;
  logic           step_rise;

  edge_detect u_step_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sig  (i_step),
    .o_rise (step_rise)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    halt_cnt_d  = halt_cnt_q;
    cycle_d     = cycle_q;
    flag_d      = 1'b0;
    addr_d      = addr_q;
    instr_d     = instr_q;
    load_full_d = load_full_q;

    unique case (state_q)
      StLoad: begin
        if (i_word_valid) begin
          flag_d  = 1'b1;
          addr_d  = ptr_q;
          instr_d = i_word;
          ptr_d   = ptr_q + LEN'(1);
          if ((i_word == HALT_WORD) || (ptr_q == LastAddr)) begin
            // Mode is latched only here; later flag changes have no effect.
            state_d     = i_step_mode_flag ? StStep : StRun;
            load_full_d = (i_word != HALT_WORD);
          end
        end
      end
      StRun, StStep: begin
        // Only enabled cycles advance the pipeline, so only they may count.
        if (cpu_en_q) begin
          if (cycle_q != 32'hFFFF_FFFF) begin
            cycle_d = cycle_q + 32'd1;
          end
          if ((i_ifid_instr == HALT_WORD) || (halt_cnt_q != '0)) begin
            halt_cnt_d = halt_cnt_q + HcW'(1);
            if (halt_cnt_d == DrainCnt) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
      end
    endcase

    // Outputs are registered versions of the next state; DONE wins over a step edge.
    cpu_en_d  = (state_d == StRun) ||
                ((state_q == StStep) && (state_d == StStep) && step_rise);
    cpu_rst_d = (state_d == StLoad);
    halted_d  = (state_d == StDone);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StLoad;
      ptr_q       <= '0;
      halt_cnt_q  <= '0;
      cycle_q     <= '0;
      flag_q      <= 1'b0;
      addr_q      <= '0;
      instr_q     <= '0;
      cpu_rst_q   <= 1'b1;
      cpu_en_q    <= 1'b0;
      halted_q    <= 1'b0;
      load_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      halt_cnt_q  <= halt_cnt_d;
      cycle_q     <= cycle_d;
      flag_q      <= flag_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      cpu_rst_q   <= cpu_rst_d;
      cpu_en_q    <= cpu_en_d;
      halted_q    <= halted_d;
      load_full_q <= load_full_d;
    end
  end

  assign o_word_ready          = (state_q == StLoad);
  assign o_preload_flag        = flag_q;
  assign o_preload_address     = addr_q;
  assign o_preload_instruction = instr_q;
  assign o_cpu_rst             = cpu_rst_q;
  assign o_cpu_en              = cpu_en_q;
  assign o_cycle_count         = cycle_q;
  assign o_halted              = halted_q;
  assign o_load_full           = load_full_q;
  assign o_state               = state_q;

endmodule

// File: tb/tb_preload_exec_ctrl.sv
// Self-checking bench for preload_exec_ctrl: directed loads/runs plus random programs.
module tb_preload_exec_ctrl;

  localparam int unsigned LEN   = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned DRAIN = 4;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_word_valid = 1'b0;
  logic [31:0] i_word = '0;
  logic        o_word_ready;
  logic        i_step_mode_flag = 1'b0;
  logic        i_step = 1'b0;
  logic [31:0] i_ifid_instr = '0;
  logic        o_preload_flag;
  logic [31:0] o_preload_address;
  logic [31:0] o_preload_instruction;
  logic        o_cpu_rst;
  logic        o_cpu_en;
  logic [31:0] o_cycle_count;
  logic        o_halted;
  logic        o_load_full;
  logic [1:0]  o_state;

  always #5 i_clk = ~i_clk;

  preload_exec_ctrl #(
    .LEN               (LEN),
    .RAM_DEPTH_PROGRAM (DEPTH),
    .HALT_WORD         (HALT),
    .DRAIN_CYCLES      (DRAIN)
  ) dut (
    .i_clk                 (i_clk),
    .i_rst                 (i_rst),
    .i_word_valid          (i_word_valid),
    .i_word                (i_word),
    .o_word_ready          (o_word_ready),
    .i_step_mode_flag      (i_step_mode_flag),
    .i_step                (i_step),
    .i_ifid_instr          (i_ifid_instr),
    .o_preload_flag        (o_preload_flag),
    .o_preload_address     (o_preload_address),
    .o_preload_instruction (o_preload_instruction),
    .o_cpu_rst             (o_cpu_rst),
    .o_cpu_en              (o_cpu_en),
    .o_cycle_count         (o_cycle_count),
    .o_halted              (o_halted),
    .o_load_full           (o_load_full),
    .o_state               (o_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];

  // Reference model of the execution phase, in terms of counts.
  bit m_stepm;
  bit m_rise;
  bit m_prev_s;
  bit m_done;
  int m_count;
  int m_hc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  task automatic sample_strobe();
    if (o_preload_flag) begin
      obs_addr.push_back(int'(o_preload_address));
      obs_data.push_back(o_preload_instruction);
      obs_cyc.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    i_rst        = 1'b1;
    i_word_valid = 1'b0;
    i_step       = 1'b0;
    i_ifid_instr = rnd_word();
    tick();
    tick();
    check_eq("rst_state", 64'(o_state), 64'd0);
    check_eq("rst_cpu_rst", 64'(o_cpu_rst), 64'd1);
    check_eq("rst_cpu_en", 64'(o_cpu_en), 64'd0);
    check_eq("rst_count", 64'(o_cycle_count), 64'd0);
    check_eq("rst_flag", 64'(o_preload_flag), 64'd0);
    check_eq("rst_addr", 64'(o_preload_address), 64'd0);
    check_eq("rst_instr", 64'(o_preload_instruction), 64'd0);
    check_eq("rst_halted", 64'(o_halted), 64'd0);
    check_eq("rst_full", 64'(o_load_full), 64'd0);
    check_eq("rst_ready", 64'(o_word_ready), 64'd1);
    i_rst = 1'b0;
  endtask

  // mode: 0 = valid held high, 1 = valid toggling, 2 = random valid
  task automatic load_prog(input logic [31:0] w[$], input int mode, input bit stepm);
    int idx;
    int guard;
    int last;
    bit v;
    last = w.size() - 1;
    for (int i = 0; i < w.size(); i++) begin
      if (w[i] == HALT && i < last) last = i;
    end
    if (last > DEPTH - 1) last = DEPTH - 1;
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    i_step           = 1'b0;
    i_step_mode_flag = stepm;
    idx   = 0;
    guard = 0;
    while (idx <= last && guard < 1000) begin
      sample_strobe();
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
      i_word_valid = v;
      i_word       = v ? w[idx] : $urandom;
      if (v) begin
        check_eq("ready_in_load", 64'(o_word_ready), 64'd1);
        idx++;
      end
      tick();
      guard++;
    end
    i_word_valid = 1'b0;
    if (idx <= last) check_eq("load_timeout", 64'(idx), 64'(last + 1));
    sample_strobe();
    check_eq("n_strobes", 64'(obs_addr.size()), 64'(last + 1));
    for (int i = 0; i < obs_addr.size() && i <= last; i++) begin
      check_eq("strobe_addr", 64'(obs_addr[i]), 64'(i));
      check_eq("strobe_data", 64'(obs_data[i]), 64'(w[i]));
    end
    if (mode == 0 && obs_cyc.size() > 0)
      check_eq("strobe_consecutive", 64'(obs_cyc[obs_cyc.size()-1] - obs_cyc[0]), 64'(last));
    check_eq("exit_state", 64'(o_state), stepm ? 64'd2 : 64'd1);
    check_eq("exit_cpu_rst", 64'(o_cpu_rst), 64'd0);
    check_eq("exit_ready", 64'(o_word_ready), 64'd0);
    check_eq("load_full", 64'(o_load_full), 64'(w[last] != HALT));
    m_stepm  = stepm;
    m_rise   = 1'b0;
    m_prev_s = 1'b0;
    m_done   = 1'b0;
    m_count  = 0;
    m_hc     = 0;
  endtask

  // sv gives scripted step levels; beyond it the step level is random.
  // From cycle halt_from (if >=0) the IF/ID latch holds HALT until the drain starts.
  task automatic exec_phase(input bit sv[$], input int halt_from, input int ncyc);
    bit          s;
    bit          en;
    logic [31:0] ifid;
    for (int t = 0; t < ncyc; t++) begin
      en = !m_done && (m_stepm ? m_rise : 1'b1);
      check_eq("cpu_en", 64'(o_cpu_en), 64'(en));
      check_eq("state", 64'(o_state), m_done ? 64'd3 : (m_stepm ? 64'd2 : 64'd1));
      check_eq("cycle_count", 64'(o_cycle_count), 64'(m_count));
      check_eq("halted", 64'(o_halted), 64'(m_done));
      check_eq("cpu_rst_exec", 64'(o_cpu_rst), 64'd0);
      if (halt_from >= 0 && t >= halt_from && m_hc == 0) ifid = HALT;
      else if (m_hc > 0) ifid = $urandom;
      else ifid = rnd_word();
      s = (t < sv.size()) ? sv[t] : 1'($urandom_range(0, 1));
      i_ifid_instr     = ifid;
      i_step           = s;
      i_step_mode_flag = 1'($urandom_range(0, 1));
      if (en) begin
        m_count++;
        if (ifid == HALT || m_hc > 0) m_hc++;
        if (m_hc == DRAIN) m_done = 1'b1;
      end
      m_rise   = s && !m_prev_s;
      m_prev_s = s;
      tick();
    end
  endtask

  initial begin
    logic [31:0] prog[$];
    bit          sv[$];
    int          len;

    do_reset();

    // Three words ending in HALT, then run and halt at relative cycle 7.
    prog = '{32'h2001_0005, 32'h2002_0003, HALT};
    load_prog(prog, 0, 1'b0);
    check_eq("exit_strobe_addr", 64'(o_preload_address), 64'd2);
    sv.delete();
    exec_phase(sv, 7, 20);
    check_eq("halt_count_frozen", 64'(o_cycle_count), 64'(7 + DRAIN));
    check_eq("halt_state_done", 64'(o_state), 64'd3);

    // Step mode: held-high step, then three separate pulses.
    do_reset();
    prog = '{32'h0000_1234, HALT};
    load_prog(prog, 0, 1'b1);
    sv.delete();
    repeat (10) sv.push_back(1'b1);
    sv.push_back(1'b0); sv.push_back(1'b1); sv.push_back(1'b0); sv.push_back(1'b1);
    sv.push_back(1'b0); sv.push_back(1'b1); sv.push_back(1'b0); sv.push_back(1'b0);
    exec_phase(sv, -1, sv.size());
    check_eq("step_pulses", 64'(o_cycle_count), 64'd4);
    // HALT sits in IF/ID with no step for 4 cycles, then alternating steps drain it.
    sv.delete();
    repeat (4) sv.push_back(1'b0);
    repeat (12) begin sv.push_back(1'b1); sv.push_back(1'b0); end
    exec_phase(sv, 0, sv.size());
    check_eq("step_halt_count", 64'(o_cycle_count), 64'(4 + DRAIN));
    check_eq("step_halt_done", 64'(o_state), 64'd3);

    // Full memory without HALT.
    do_reset();
    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back(rnd_word());
    load_prog(prog, 0, 1'b0);
    check_eq("full_flag", 64'(o_load_full), 64'd1);
    sv.delete();
    exec_phase(sv, 3, 12);

    // Toggling valid.
    do_reset();
    prog = '{rnd_word(), rnd_word(), rnd_word(), rnd_word(), rnd_word(), HALT};
    load_prog(prog, 1, 1'b0);
    check_eq("toggle_full", 64'(o_load_full), 64'd0);

    // Reset after two of five words.
    do_reset();
    i_word_valid = 1'b1;
    i_word       = 32'h1111_0000;
    tick();
    i_word       = 32'h2222_0001;
    tick();
    check_eq("midload_flag", 64'(o_preload_flag), 64'd1);
    check_eq("midload_addr", 64'(o_preload_address), 64'd1);
    i_rst  = 1'b1;
    i_word = 32'h3333_0002;
    tick();
    check_eq("abort_flag", 64'(o_preload_flag), 64'd0);
    check_eq("abort_addr", 64'(o_preload_address), 64'd0);
    check_eq("abort_state", 64'(o_state), 64'd0);
    i_rst        = 1'b0;
    i_word_valid = 1'b0;
    prog = '{32'hAAAA_0000, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, HALT};
    load_prog(prog, 2, 1'b0);

    // Random programs, valid patterns, modes and halt positions.
    repeat (6) begin
      do_reset();
      prog.delete();
      len = $urandom_range(1, DEPTH + 8);
      for (int i = 0; i < len; i++) prog.push_back(rnd_word());
      if (len <= DEPTH) prog[len-1] = HALT;
      load_prog(prog, 2, 1'($urandom_range(0, 1)));
      sv.delete();
      exec_phase(sv, $urandom_range(0, 20), 90);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/preload_exec_ctrl.md
PRELOAD_EXEC_CTRL -- requirements
Module: preload_exec_ctrl

Interface
REQ-001 SHALL have parameter LEN, default 32, the width of data words and preload addresses.
REQ-002 SHALL have parameter RAM_DEPTH_PROGRAM, default 32, the number of program memory words.
REQ-003 SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, the halt instruction encoding.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 4, the enabled cycles from halt-in-IF/ID to DONE.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-006 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port i_word_valid, input, 1 bit: the program word source has a word.
REQ-008 SHALL have port i_word, input, LEN bits: the program word.
REQ-009 SHALL have port o_word_ready, output, 1 bit: the controller accepts a word.
REQ-010 SHALL have port i_step_mode_flag, input, 1 bit: 1 selects step mode, 0 selects continuous mode; sampled when LOAD exits.
REQ-011 SHALL have port i_step, input, 1 bit: step request, already synchronous to i_clk.
REQ-012 SHALL have port i_ifid_instr, input, LEN bits: the instruction field of the IF/ID latch.
REQ-013 SHALL have port o_preload_flag, output, 1 bit: program memory write strobe.
REQ-014 SHALL have port o_preload_address, output, LEN bits: program memory write address.
REQ-015 SHALL have port o_preload_instruction, output, LEN bits: program memory write data.
REQ-016 SHALL have port o_cpu_rst, output, 1 bit: holds the pipeline in reset, active-high.
REQ-017 SHALL have port o_cpu_en, output, 1 bit: pipeline advance enable for this cycle.
REQ-018 SHALL have port o_cycle_count, output, 32 bits: count of enabled execution cycles.
REQ-019 SHALL have port o_halted, output, 1 bit: high while in DONE.
REQ-020 SHALL have port o_load_full, output, 1 bit: sticky flag, load ended by a full memory rather than by HALT_WORD.
REQ-021 SHALL have port o_state, output, 2 bits: the current state code.

Function
REQ-022 SHALL implement the states LOAD=0, RUN=1, STEP=2 and DONE=3.
REQ-023 SHALL drive all outputs from registers, except o_word_ready, which SHALL equal (state==LOAD).
REQ-024 SHALL, in LOAD, on each i_word_valid&&o_word_ready handshake, assert o_preload_flag for exactly the next cycle, with o_preload_address=ptr and o_preload_instruction=i_word, and then increment ptr.
REQ-025 SHALL write a HALT_WORD to memory like any other word, then leave LOAD.
REQ-026 SHALL leave LOAD after a handshake at ptr==RAM_DEPTH_PROGRAM-1, and SHALL then set o_load_full if that word was not HALT_WORD.
REQ-027 SHALL, on leaving LOAD, go to STEP if i_step_mode_flag==1 and otherwise to RUN; o_cpu_rst SHALL fall in the same cycle that o_state changes.
REQ-028 SHALL hold o_cpu_rst=1 in LOAD and o_cpu_rst=0 in every other state.
REQ-029 SHALL hold o_cpu_en=1 in RUN, and 0 in LOAD and in DONE.
REQ-030 SHALL, in STEP, assert o_cpu_en for exactly one cycle, one cycle after each rising edge of i_step (i_step && !step_q); a held-high i_step SHALL yield one pulse only.
REQ-031 SHALL, in any cycle with o_cpu_en=1, increment o_cycle_count, saturating at 32'hFFFFFFFF.
REQ-032 SHALL, in any cycle with o_cpu_en=1 and either i_ifid_instr==HALT_WORD or halt_cnt>0, increment halt_cnt.
REQ-033 SHALL enter DONE in the cycle after halt_cnt reaches DRAIN_CYCLES.
REQ-034 SHALL hold DONE, with o_halted=1 and o_cycle_count frozen, until i_rst.
REQ-035 SHALL ignore i_ifid_instr outside enabled cycles, so a HALT_WORD seen in STEP with no step pulse counts nothing.
REQ-036 SHALL, when a step edge coincides with the final drain count, let DONE take priority and issue no further o_cpu_en.
REQ-037 SHALL ignore i_step_mode_flag changes after LOAD exits.

Reset
REQ-038 SHALL, on i_rst=1 at a clock edge, set state=LOAD, ptr=0, halt_cnt=0 and o_cycle_count=0.
REQ-039 SHALL, on the same reset, set o_preload_flag=0, o_preload_address=0, o_preload_instruction=0, o_cpu_en=0, o_cpu_rst=1, o_halted=0, o_load_full=0 and step_q=0.
REQ-040 SHALL, on reset from any state (mid-load, RUN, STEP or DONE), abort with no partial write strobe and restart loading at address 0.

Structure
REQ-041 SHALL take HALT_WORD and the state encodings from shared package mips_pkg.
REQ-042 SHALL implement step edge detection as sub-module edge_detect (input i_clk, i_rst, i_sig; output o_rise).

Verification
REQ-043 SHALL verify this: 3 words {0x20010005, 0x20020003, 0xFFFFFFFF}, valid held high -> three strobes at addresses 0,1,2 on consecutive cycles, then state=RUN and o_cpu_rst=0.
REQ-044 SHALL verify this: RUN with i_ifid_instr=HALT_WORD first seen on enabled cycle N -> DONE at cycle N+4, and o_cycle_count frozen at (count at N)+4.
REQ-045 SHALL verify this: step mode with i_step held high for 10 cycles, then 3 separate pulses -> exactly 4 o_cpu_en pulses, and o_cycle_count=4.
REQ-046 SHALL verify this: 32 non-halt words -> 32 strobes at addresses 0..31, then o_load_full=1 and state=RUN.
REQ-047 SHALL verify this: i_rst asserted after 2 of 5 loaded words -> o_preload_flag=0 next cycle, and the subsequent load starts at address 0.
REQ-048 SHALL verify this: i_word_valid toggling 1,0,1,0 -> one strobe per accepted word, and addresses remain contiguous.
